// File: rtl/cop_mem_seq_pkg.sv
// Shared types for the coprocessor memory sequencer.
// States, per-transaction record and address alignment mask.
package cop_mem_seq_pkg;

    localparam int NTXN_DEF = 4;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        logic        wen;
    } txn_t;

endpackage

// File: rtl/cop_mem_if.sv
// Single-port coprocessor memory bus.
// master = sequencer side, slave = memory side.
interface cop_mem_if;

    logic        mem_cen;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_ben;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        mem_error;

    modport master (
        output mem_cen,
        output mem_wen,
        output mem_addr,
        output mem_wdata,
        output mem_ben,
        input  mem_stall,
        input  mem_rdata,
        input  mem_error
    );

    modport slave (
        input  mem_cen,
        input  mem_wen,
        input  mem_addr,
        input  mem_wdata,
        input  mem_ben,
        output mem_stall,
        output mem_rdata,
        output mem_error
    );

endinterface

// File: rtl/cop_mem_seq_trace.sv
// Per-transaction trace capture for the memory sequencer.
// Only instantiated when COP_MEM_SEQ_TRACE_EN is defined.
module cop_mem_seq_trace
    import cop_mem_seq_pkg::*;
#(
    parameter int IDXW = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cap,
    input  logic [IDXW-1:0] idx,
    input  txn_t            txn,
    input  logic [31:0]     rdata,
    input  logic            error,
    output logic            trc_valid,
    output logic [IDXW-1:0] trc_idx,
    output logic            trc_wen,
    output logic [31:0]     trc_addr,
    output logic [31:0]     trc_wdata,
    output logic [31:0]     trc_rdata,
    output logic [3:0]      trc_ben,
    output logic            trc_error
);

    // One registered pulse per response cycle, carrying that cycle's bus data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            trc_valid <= 1'b0;
            trc_idx   <= '0;
            trc_wen   <= 1'b0;
            trc_addr  <= '0;
            trc_wdata <= '0;
            trc_rdata <= '0;
            trc_ben   <= '0;
            trc_error <= 1'b0;
        end else begin
            trc_valid <= cap;
            if (cap) begin
                trc_idx   <= idx;
                trc_wen   <= txn.wen;
                trc_addr  <= txn.addr;
                trc_wdata <= txn.wdata;
                trc_rdata <= rdata;
                trc_ben   <= txn.ben;
                trc_error <= error;
            end
        end
    end

endmodule

// File: rtl/cop_mem_seq.sv
// Sequences a batch of up to NTXN word transactions onto the cop memory port.
// Optional trace outputs: define COP_MEM_SEQ_TRACE_EN.
module cop_mem_seq
    import cop_mem_seq_pkg::*;
#(
    parameter int NTXN = NTXN_DEF,
    parameter int IDXW = (NTXN > 1) ? $clog2(NTXN) : 1
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_count,
    input  logic               req_wen,
    input  logic [NTXN*32-1:0] req_addr,
    input  logic [NTXN*32-1:0] req_wdata,
    input  logic [NTXN*4-1:0]  req_ben,
    input  logic               flush,
    output logic               rsp_valid,
    output logic               rsp_error,
    output logic [NTXN*32-1:0] rsp_rdata,
    cop_mem_if.master          mem_bus
`ifdef COP_MEM_SEQ_TRACE_EN
    ,
    output logic               trc_valid,
    output logic [IDXW-1:0]    trc_idx,
    output logic               trc_wen,
    output logic [31:0]        trc_addr,
    output logic [31:0]        trc_wdata,
    output logic [31:0]        trc_rdata,
    output logic [3:0]         trc_ben,
    output logic               trc_error
`endif
);

    state_t             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [IDXW-1:0]    last_q, last_d;
    logic [IDXW-1:0]    nxt_idx;
    logic               flushed_q, flushed_d;
    logic               err_q, err_d;
    logic               wen_q;
    logic [NTXN*32-1:0] rdata_q, rdata_d;
    logic               cen_q, cen_d;
    logic               mwen_q, mwen_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         ben_q, ben_d;
    txn_t               txn_q [NTXN];
    logic               accept;
    logic [2:0]         cnt_c;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_error = err_q;
    assign rsp_rdata = rdata_q;
    assign accept    = req_valid & req_ready;
    assign cnt_c     = (req_count > 3'(NTXN)) ? 3'(NTXN) : req_count;

    assign mem_bus.mem_cen   = cen_q;
    assign mem_bus.mem_wen   = mwen_q;
    assign mem_bus.mem_addr  = addr_q;
    assign mem_bus.mem_wdata = wdata_q;
    assign mem_bus.mem_ben   = ben_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        flushed_d = flushed_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cen_d     = cen_q;
        mwen_d    = mwen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ben_d     = ben_q;
        nxt_idx   = idx_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d     = '0;
                    err_d     = 1'b0;
                    flushed_d = 1'b0;
                    rdata_d   = '0;
                    last_d    = IDXW'(cnt_c - 3'd1);
                    if (cnt_c == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        // txn 0 is loaded straight into the bus registers
                        state_d = ISSUE;
                        cen_d   = 1'b1;
                        mwen_d  = req_wen;
                        addr_d  = req_addr[31:0] & WORD_ALIGN_MASK;
                        wdata_d = req_wdata[31:0];
                        ben_d   = req_ben[3:0];
                    end
                end
            end
            ISSUE: begin
                if (!mem_bus.mem_stall) begin
                    state_d   = RESP;
                    cen_d     = 1'b0;
                    mwen_d    = 1'b0;
                    flushed_d = flush;
                end else if (flush) begin
                    state_d = IDLE;
                    cen_d   = 1'b0;
                    mwen_d  = 1'b0;
                end
            end
            RESP: begin
                if (flushed_q || flush) begin
                    state_d = IDLE;
                end else if (mem_bus.mem_error) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    if (!wen_q) begin
                        rdata_d[idx_q*32 +: 32] = mem_bus.mem_rdata;
                    end
                    if (idx_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = nxt_idx;
                        cen_d   = 1'b1;
                        mwen_d  = txn_q[nxt_idx].wen;
                        addr_d  = txn_q[nxt_idx].addr;
                        wdata_d = txn_q[nxt_idx].wdata;
                        ben_d   = txn_q[nxt_idx].ben;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            last_q    <= '0;
            flushed_q <= 1'b0;
            err_q     <= 1'b0;
            wen_q     <= 1'b0;
            rdata_q   <= '0;
            cen_q     <= 1'b0;
            mwen_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ben_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            flushed_q <= flushed_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cen_q     <= cen_d;
            mwen_q    <= mwen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ben_q     <= ben_d;
            if (accept) begin
                wen_q <= req_wen;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (accept) begin
            for (int i = 0; i < NTXN; i++) begin
                txn_q[i].addr  <= req_addr[32*i +: 32] & WORD_ALIGN_MASK;
                txn_q[i].wdata <= req_wdata[32*i +: 32];
                txn_q[i].ben   <= req_ben[4*i +: 4];
                txn_q[i].wen   <= req_wen;
            end
        end
    end

`ifdef COP_MEM_SEQ_TRACE_EN
    cop_mem_seq_trace #(
        .IDXW (IDXW)
    ) u_trace (
        .clk       (g_clk),
        .resetn    (g_resetn),
        .cap       (state_q == RESP),
        .idx       (idx_q),
        .txn       (txn_q[idx_q]),
        .rdata     (mem_bus.mem_rdata),
        .error     (mem_bus.mem_error),
        .trc_valid (trc_valid),
        .trc_idx   (trc_idx),
        .trc_wen   (trc_wen),
        .trc_addr  (trc_addr),
        .trc_wdata (trc_wdata),
        .trc_rdata (trc_rdata),
        .trc_ben   (trc_ben),
        .trc_error (trc_error)
    );
`endif

endmodule

// File: tb/tb_cop_mem_seq.sv
// Directed bench for cop_mem_seq with a responding memory model.
// Memory returns addr ^ K one cycle after acceptance; err_addr errors.
module tb_cop_mem_seq;

    localparam int NTXN = 4;
    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic               g_clk = 1'b0;
    logic               g_resetn;
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_count;
    logic               req_wen;
    logic [NTXN*32-1:0] req_addr;
    logic [NTXN*32-1:0] req_wdata;
    logic [NTXN*4-1:0]  req_ben;
    logic               flush;
    logic               rsp_valid;
    logic               rsp_error;
    logic [NTXN*32-1:0] rsp_rdata;

`ifdef COP_MEM_SEQ_TRACE_EN
    logic        trc_valid;
    logic [1:0]  trc_idx;
    logic        trc_wen;
    logic [31:0] trc_addr;
    logic [31:0] trc_wdata;
    logic [31:0] trc_rdata;
    logic [3:0]  trc_ben;
    logic        trc_error;
`endif

    cop_mem_if mem_bus ();

    cop_mem_seq #(.NTXN(NTXN)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_count (req_count),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ben   (req_ben),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_error (rsp_error),
        .rsp_rdata (rsp_rdata),
        .mem_bus   (mem_bus)
`ifdef COP_MEM_SEQ_TRACE_EN
        ,
        .trc_valid (trc_valid),
        .trc_idx   (trc_idx),
        .trc_wen   (trc_wen),
        .trc_addr  (trc_addr),
        .trc_wdata (trc_wdata),
        .trc_rdata (trc_rdata),
        .trc_ben   (trc_ben),
        .trc_error (trc_error)
`endif
    );

    always #5 g_clk = ~g_clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rsp_cyc = -1;
    int          rsp_cnt = 0;
    int          txn_cnt = 0;
    int          r0;
    logic [31:0] addr_log [$];
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] a_snap;
    logic [127:0] exp_rd;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; sees the current cycle's bus, then advances.
    task automatic tick();
        logic        took;
        logic [31:0] a;
        took = (mem_bus.mem_cen === 1'b1) && (mem_bus.mem_stall === 1'b0);
        a    = mem_bus.mem_addr;
        if (took) begin
            txn_cnt++;
            addr_log.push_back(a);
        end
        @(posedge g_clk);
        #1;
        cyc++;
        if (took) begin
            mem_bus.mem_rdata = a ^ K;
            mem_bus.mem_error = (a == err_addr);
        end else begin
            mem_bus.mem_rdata = '0;
            mem_bus.mem_error = 1'b0;
        end
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            rsp_cyc = cyc;
        end
    endtask

    task automatic start(input logic [2:0] cnt, input logic wen);
        req_count = cnt;
        req_wen   = wen;
        req_valid = 1'b1;
        acc_cyc   = cyc;
        rsp_cyc   = -1;
        txn_cnt   = 0;
        addr_log.delete();
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max);
        for (int i = 0; i < max && rsp_cyc < 0; i++) tick();
    endtask

    initial begin
        g_resetn  = 1'b0;
        req_valid = 1'b0;
        req_count = '0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_ben   = '0;
        flush     = 1'b0;
        mem_bus.mem_stall = 1'b0;
        mem_bus.mem_rdata = '0;
        mem_bus.mem_error = 1'b0;
        tick();
        tick();
        check("rst_ready", 128'(req_ready), 128'd1);
        check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("rst_rsp_error", 128'(rsp_error), 128'd0);
        check("rst_rdata", rsp_rdata, 128'd0);
        check("rst_cen", 128'(mem_bus.mem_cen), 128'd0);
        check("rst_addr", 128'(mem_bus.mem_addr), 128'd0);
        g_resetn = 1'b1;
        tick();

        // 1: four-word load, no stall
        req_addr = {32'h10C, 32'h108, 32'h104, 32'h100};
        req_ben  = 16'hFFFF;
        start(3'd4, 1'b0);
        wait_rsp(30);
        check("t1_latency", 128'(rsp_cyc - acc_cyc), 128'd9);
        check("t1_ntxn", 128'(txn_cnt), 128'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), 128'(addr_log[i]),
                  128'(32'h100 + 32'(4 * i)));
        end
        exp_rd = {32'h10C ^ K, 32'h108 ^ K, 32'h104 ^ K, 32'h100 ^ K};
        check("t1_rdata", rsp_rdata, exp_rd);
        check("t1_error", 128'(rsp_error), 128'd0);
        tick();
        check("t1_pulse", 128'(rsp_valid), 128'd0);
        check("t1_ready", 128'(req_ready), 128'd1);
        check("t1_hold", rsp_rdata, exp_rd);

        // 2: two-word store, txn 0 stalled three cycles
        req_addr  = {64'h0, 32'h207, 32'h200};
        req_wdata = {64'h0, 32'h1234_5678, 32'hDEAD_BEEF};
        req_ben   = {8'h0, 4'hC, 4'h3};
        start(3'd2, 1'b1);
        mem_bus.mem_stall = 1'b1;
        check("t2_cen", 128'(mem_bus.mem_cen), 128'd1);
        check("t2_wen", 128'(mem_bus.mem_wen), 128'd1);
        repeat (2) begin
            tick();
            check("t2_stl_cen", 128'(mem_bus.mem_cen), 128'd1);
            check("t2_stl_addr", 128'(mem_bus.mem_addr), 128'h200);
            check("t2_stl_wdata", 128'(mem_bus.mem_wdata), 128'hDEAD_BEEF);
            check("t2_stl_ben", 128'(mem_bus.mem_ben), 128'h3);
        end
        tick();
        mem_bus.mem_stall = 1'b0;
        wait_rsp(30);
        check("t2_latency", 128'(rsp_cyc - acc_cyc), 128'd8);
        check("t2_ntxn", 128'(txn_cnt), 128'd2);
        check("t2_addr1", 128'(addr_log[1]), 128'h204);
        check("t2_rdata", rsp_rdata, 128'd0);
        tick();

        // 3: three-word load, error on txn 1
        req_addr = {32'h0, 32'h308, 32'h304, 32'h300};
        req_ben  = 16'hFFFF;
        err_addr = 32'h304;
        start(3'd3, 1'b0);
        wait_rsp(30);
        check("t3_latency", 128'(rsp_cyc - acc_cyc), 128'd5);
        check("t3_ntxn", 128'(txn_cnt), 128'd2);
        check("t3_error", 128'(rsp_error), 128'd1);
        check("t3_slot0", 128'(rsp_rdata[31:0]), 128'(32'h300 ^ K));
        err_addr = 32'hFFFF_FFFF;
        tick();

        // 4: empty batch, then over-range count clamps to NTXN
        start(3'd0, 1'b0);
        wait_rsp(10);
        check("t4_zero_latency", 128'(rsp_cyc - acc_cyc), 128'd1);
        check("t4_zero_ntxn", 128'(txn_cnt), 128'd0);
        check("t4_zero_error", 128'(rsp_error), 128'd0);
        tick();
        req_addr = {32'h10C, 32'h108, 32'h104, 32'h100};
        start(3'd7, 1'b0);
        wait_rsp(30);
        check("t4_clamp_ntxn", 128'(txn_cnt), 128'd4);
        check("t4_clamp_latency", 128'(rsp_cyc - acc_cyc), 128'd9);
        check("t4_clamp_last", 128'(addr_log[3]), 128'h10C);
        tick();

        // 5a: flush while stalled in ISSUE
        r0 = rsp_cnt;
        start(3'd2, 1'b0);
        mem_bus.mem_stall = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        check("t5a_cen", 128'(mem_bus.mem_cen), 128'd0);
        check("t5a_ready", 128'(req_ready), 128'd1);
        flush = 1'b0;
        mem_bus.mem_stall = 1'b0;
        repeat (4) tick();
        check("t5a_no_rsp", 128'(rsp_cnt - r0), 128'd0);
        check("t5a_ntxn", 128'(txn_cnt), 128'd0);

        // 5b: flush as the request is taken
        r0 = rsp_cnt;
        start(3'd2, 1'b0);
        flush = 1'b1;
        tick();
        check("t5b_resp_cen", 128'(mem_bus.mem_cen), 128'd0);
        check("t5b_resp_ready", 128'(req_ready), 128'd0);
        flush = 1'b0;
        tick();
        check("t5b_ready", 128'(req_ready), 128'd1);
        repeat (4) tick();
        check("t5b_no_rsp", 128'(rsp_cnt - r0), 128'd0);
        check("t5b_ntxn", 128'(txn_cnt), 128'd1);

        // 6: reset asserted during RESP, then a normal batch
        start(3'd4, 1'b0);
        tick();
        a_snap = mem_bus.mem_addr;
        check("t6_pre_addr", 128'(a_snap), 128'h100);
        g_resetn = 1'b0;
        tick();
        check("t6_ready", 128'(req_ready), 128'd1);
        check("t6_rsp_valid", 128'(rsp_valid), 128'd0);
        check("t6_rsp_error", 128'(rsp_error), 128'd0);
        check("t6_rdata", rsp_rdata, 128'd0);
        check("t6_cen", 128'(mem_bus.mem_cen), 128'd0);
        check("t6_wen", 128'(mem_bus.mem_wen), 128'd0);
        check("t6_addr", 128'(mem_bus.mem_addr), 128'd0);
        check("t6_wdata", 128'(mem_bus.mem_wdata), 128'd0);
        check("t6_ben", 128'(mem_bus.mem_ben), 128'd0);
        g_resetn = 1'b1;
        tick();
        req_addr = {96'h0, 32'h400};
        start(3'd1, 1'b0);
        wait_rsp(20);
        check("t6_new_latency", 128'(rsp_cyc - acc_cyc), 128'd3);
        check("t6_new_ntxn", 128'(txn_cnt), 128'd1);
        check("t6_new_slot0", 128'(rsp_rdata[31:0]), 128'(32'h400 ^ K));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
